gp_register: RTL and testbench



---
 rtl/gp_register.sv | 27 ++
 tb/tb_gp_register.sv | 111 +++++++++++
 2 files changed

// File: rtl/gp_register.sv
// General-purpose signed storage register with a per-instance asynchronous reset value.
// Output comes straight from the flops, so there is no combinational path from Input or RegWrite.
module gp_register #(
   parameter int WIDTH = 16
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic signed [WIDTH-1:0] Input,
   input  logic                    RegWrite,
   input  logic signed [WIDTH-1:0] ResetTo,
   output logic signed [WIDTH-1:0] Output
);

   logic signed [WIDTH-1:0] store;

   // ResetTo is held stable by the instantiating logic for as long as Reset is low.
   // While Reset stays low, each CLK edge reloads that same value.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         store <= ResetTo;
      else if (RegWrite == 1'b1)
         store <= Input;
   end

   assign Output = store;

endmodule

// File: tb/tb_gp_register.sv
// Scoreboard bench for gp_register: stimulus pushes the expected value, and a negedge monitor pops and compares it.
module tb_gp_register;

   localparam int W = 16;

   logic                CLK = 1'b0;
   logic                Reset = 1'b0;
   logic signed [W-1:0] Input = '0;
   logic                RegWrite = 1'b0;
   logic signed [W-1:0] ResetTo = '0;
   logic signed [W-1:0] Output;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [W-1:0] value;
      string        tag;
   } exp_t;
   exp_t exp_q[$];

   // Architectural value of the register, from the plain rules: reset wins, then write, then hold.
   logic [W-1:0] model;

   gp_register #(.WIDTH(W)) dut (
      .CLK(CLK),
      .Reset(Reset),
      .Input(Input),
      .RegWrite(RegWrite),
      .ResetTo(ResetTo),
      .Output(Output)
   );

   always #5 CLK = ~CLK;

   // Monitor: sample mid-cycle, away from the rising edge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         compared++;
         if (Output !== e.value) begin
            mismatched++;
            $display("FAIL %s: Output=%h expected=%h at %0t", e.tag, Output, e.value, $time);
         end
      end
   end

   // One cycle of stimulus: the edge applies the inputs already present. New inputs are then
   // driven between edges, and an asserted reset takes effect at once.
   task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                       input logic [W-1:0] rt, input string tag);
      @(posedge CLK);
      if (!Reset) model = ResetTo;
      else if (RegWrite) model = Input;
      #1;
      Reset = r; RegWrite = w; Input = d; ResetTo = rt;
      if (!r) model = rt;
      exp_q.push_back('{model, tag});
   endtask

   initial begin
      logic         r, w;
      logic [W-1:0] d, rt;
      int           drain;

      model = 'x;
      // Hold reset with a pending write of 5: Output must stay at ResetTo=0.
      step(1'b0, 1'b1, 16'd5, 16'd0, "reset_hold0");
      step(1'b0, 1'b1, 16'd5, 16'd0, "reset_hold1");
      step(1'b0, 1'b1, 16'd5, 16'd0, "reset_hold2");
      step(1'b1, 1'b1, 16'd5, 16'd0, "release_nochange");
      step(1'b1, 1'b1, 16'd1, 16'd0, "first_write5");
      step(1'b1, 1'b1, 16'd1, 16'd0, "write1");
      step(1'b1, 1'b0, 16'd2, 16'd0, "rewrite1");
      step(1'b1, 1'b0, 16'd2, 16'd0, "hold_a");
      step(1'b1, 1'b0, 16'd2, 16'd0, "hold_b");
      step(1'b1, 1'b1, 16'hFFFF, 16'd0, "hold_c");
      step(1'b1, 1'b1, 16'h8000, 16'd0, "neg_one");
      step(1'b1, 1'b1, 16'h7FFF, 16'd0, "min_neg");
      step(1'b1, 1'b1, 16'd7, 16'h1234, "max_pos");
      step(1'b1, 1'b0, 16'd7, 16'h1234, "seven");
      // Async reset between edges, then release with RegWrite low.
      step(1'b0, 1'b1, 16'd9, 16'h1234, "async_1234");
      step(1'b1, 1'b0, 16'd9, 16'h1234, "release_1234");
      step(1'b1, 1'b0, 16'd9, 16'h1234, "hold_1234");

      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 11) != 0);
         w  = $urandom_range(0, 1);
         d  = W'($urandom);
         // ResetTo may only change while reset is deasserted.
         rt = Reset ? W'($urandom) : ResetTo;
         step(r, w, d, rt, "random");
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge CLK);
         drain++;
      end
      if (exp_q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: %0d pending expected values, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
